// File: rtl/ex_iter_divider.sv
// Iterative restoring radix-2 divider for the EX stage: signed/unsigned quotient or remainder,
// optional early termination on short dividends, flushable, valid/ready on both sides.
//   state | meaning
//   IDLE  | waiting for an operation (in_ready once out of reset)
//   PREP  | take magnitudes, record signs, size the iteration count, pre-shift dividend
//   ITER  | one quotient bit per cycle until the down-counter expires
//   FIX   | apply sign correction / divide-by-zero result, capture result
//   DONE  | present result until out_ready
module ex_iter_divider #(
    parameter int XLEN      = 32,
    parameter int EARLY_OUT = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            op_signed,
    input  logic            op_rem,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            live_q, live_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] div_q, div_d;
    logic [XLEN-1:0] src1_q, src1_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            op_signed_q, op_signed_d;
    logic            op_rem_q, op_rem_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            dz_q, dz_d;

    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs;
    logic [CW-1:0]   clz, n_iter;
    logic [XLEN:0]   rem_sh;
    logic            ge;
    logic [XLEN-1:0] diff;
    logic [XLEN-1:0] q_fix, r_fix;

    // Operand magnitudes and iteration count, used only in PREP
    always_comb begin
        a_neg = op_signed_q & src1_q[XLEN-1];
        b_neg = op_signed_q & div_q[XLEN-1];
        a_abs = a_neg ? -src1_q : src1_q;
        b_abs = b_neg ? -div_q : div_q;
        clz   = CW'(XLEN);
        for (int i = 0; i < XLEN; i++) begin
            if (a_abs[i]) clz = CW'(XLEN - 1 - i);
        end
        if (EARLY_OUT == 0)          n_iter = CW'(XLEN);
        else if (clz == CW'(XLEN))   n_iter = CW'(1);
        else                         n_iter = CW'(XLEN) - clz;
    end

    // Restoring step; the true difference is below |b| so XLEN bits hold it
    always_comb begin
        rem_sh = {rem_q, quo_q[XLEN-1]};
        ge     = rem_sh >= {1'b0, div_q};
        diff   = rem_sh[XLEN-1:0] - div_q;
    end

    always_comb begin
        if (dz_q) begin
            q_fix = '1;
            r_fix = src1_q;
        end else begin
            q_fix = neg_quo_q ? -quo_q : quo_q;
            r_fix = neg_rem_q ? -rem_q : rem_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        live_d      = 1'b1;
        cnt_d       = cnt_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        div_d       = div_q;
        src1_d      = src1_q;
        result_d    = result_q;
        op_signed_d = op_signed_q;
        op_rem_d    = op_rem_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        dz_d        = dz_q;
        case (state_q)
            S_IDLE: begin
                if (live_q && in_valid && !flush) begin
                    src1_d      = src1;
                    div_d       = src2;
                    op_signed_d = op_signed;
                    op_rem_d    = op_rem;
                    state_d     = S_PREP;
                end
            end
            S_PREP: begin
                neg_quo_d = a_neg ^ b_neg;
                neg_rem_d = a_neg;
                div_d     = b_abs;
                quo_d     = a_abs << (CW'(XLEN) - n_iter);
                rem_d     = '0;
                cnt_d     = n_iter;
                dz_d      = (div_q == '0);
                state_d   = (div_q == '0) ? S_FIX : S_ITER;
            end
            S_ITER: begin
                rem_d = ge ? diff : rem_sh[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], ge};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                result_d = op_rem_q ? r_fix : q_fix;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            live_q      <= 1'b0;
            cnt_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            div_q       <= '0;
            src1_q      <= '0;
            result_q    <= '0;
            op_signed_q <= 1'b0;
            op_rem_q    <= 1'b0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            live_q      <= live_d;
            cnt_q       <= cnt_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            div_q       <= div_d;
            src1_q      <= src1_d;
            result_q    <= result_d;
            op_signed_q <= op_signed_d;
            op_rem_q    <= op_rem_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            dz_q        <= dz_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE) && live_q;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;

endmodule

// File: tb/tb_ex_iter_divider.sv
// Bench for ex_iter_divider: directed corner cases plus random operations against an arithmetic
// reference, on a 32-bit early-out instance and a 64-bit fixed-latency instance.
module tb_ex_iter_divider;

    logic        clk = 1'b0;
    logic        resetn, flush, in_valid, op_signed, op_rem, out_ready;
    logic [31:0] src1, src2;
    logic        in_ready, out_valid, busy;
    logic [31:0] result;

    logic        flush64, in_valid64, op_signed64, op_rem64, out_ready64;
    logic [63:0] src1_64, src2_64;
    logic        in_ready64, out_valid64, busy64;
    logic [63:0] result64;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ex_iter_divider #(.XLEN(32), .EARLY_OUT(1)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op_signed(op_signed), .op_rem(op_rem), .src1(src1), .src2(src2),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    ex_iter_divider #(.XLEN(64), .EARLY_OUT(0)) dut64 (
        .clk(clk), .resetn(resetn), .flush(flush64), .in_valid(in_valid64), .in_ready(in_ready64),
        .op_signed(op_signed64), .op_rem(op_rem64), .src1(src1_64), .src2(src2_64),
        .out_valid(out_valid64), .out_ready(out_ready64), .result(result64), .busy(busy64)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref32(input logic s, input logic r,
                                          input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, res;
        if (b == 0) return r ? a : 32'hFFFF_FFFF;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        res = r ? (sa % sb) : (sa / sb);
        return res[31:0];
    endfunction

    function automatic int lat32(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] m;
        int bits;
        if (b == 0) return 3;
        m = (s && a[31]) ? -a : a;
        bits = 0;
        while (m != 0) begin
            bits++;
            m = m >> 1;
        end
        if (bits == 0) bits = 1;
        return 3 + bits;
    endfunction

    function automatic logic [63:0] ref64(input logic s, input logic r,
                                          input logic [63:0] a, input logic [63:0] b);
        longint sa, sb;
        if (b == 0) return r ? a : 64'hFFFF_FFFF_FFFF_FFFF;
        if (s) begin
            sa = a;
            sb = b;
            return r ? 64'(sa % sb) : 64'(sa / sb);
        end
        return r ? (a % b) : (a / b);
    endfunction

    task automatic run_op(input string tag, input logic s, input logic r,
                          input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] exp_res;
        int          exp_l, k;
        logic        seen;
        exp_res = ref32(s, r, a, b);
        exp_l   = lat32(s, a, b);
        @(negedge clk);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        op_signed = s;
        op_rem    = r;
        src1      = a;
        src2      = b;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        src1      = $urandom;
        src2      = $urandom;
        op_signed = 1'($urandom);
        op_rem    = 1'($urandom);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 200) begin
            @(negedge clk);
            k++;
            if (k == 1) chk({tag, "_busy"}, 64'(busy), 64'd1);
            if (out_valid) seen = 1'b1;
        end
        chk({tag, "_latency"}, 64'(k), 64'(exp_l));
        chk({tag, "_result"}, 64'(result), 64'(exp_res));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold"}, {31'd0, out_valid, result}, {31'd0, 1'b1, exp_res});
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_post"}, {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
    endtask

    task automatic run64(input string tag, input logic s, input logic r,
                         input logic [63:0] a, input logic [63:0] b);
        int   k;
        logic seen;
        @(negedge clk);
        in_valid64  = 1'b1;
        op_signed64 = s;
        op_rem64    = r;
        src1_64     = a;
        src2_64     = b;
        @(posedge clk);
        #1;
        in_valid64 = 1'b0;
        src1_64    = {$urandom, $urandom};
        src2_64    = {$urandom, $urandom};
        k = 0;
        seen = 1'b0;
        while (!seen && k < 200) begin
            @(negedge clk);
            k++;
            if (out_valid64) seen = 1'b1;
        end
        chk({tag, "_latency"}, 64'(k), (b == 0) ? 64'd3 : 64'd67);
        chk({tag, "_result"}, result64, ref64(s, r, a, b));
        @(negedge clk);
    endtask

    initial begin
        logic        pend;
        logic [31:0] ra, rb;
        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; op_signed = 1'b0; op_rem = 1'b0;
        out_ready = 1'b1; src1 = '0; src2 = '0;
        flush64 = 1'b0; in_valid64 = 1'b0; op_signed64 = 1'b0; op_rem64 = 1'b0;
        out_ready64 = 1'b1; src1_64 = '0; src2_64 = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {60'd0, in_ready, out_valid, busy, 1'b0}, 64'd0);
        chk("reset_result", 64'(result), 64'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 64'(in_ready), 64'd1);

        run_op("u100d7_q", 1'b0, 1'b0, 32'd100, 32'd7, 0);
        run_op("u100d7_r", 1'b0, 1'b1, 32'd100, 32'd7, 0);
        run_op("s_m7d2_q", 1'b1, 1'b0, -32'sd7, 32'd2, 0);
        run_op("s_m7d2_r", 1'b1, 1'b1, -32'sd7, 32'd2, 0);
        run_op("s_7dm2_q", 1'b1, 1'b0, 32'd7, -32'sd2, 0);
        run_op("s_7dm2_r", 1'b1, 1'b1, 32'd7, -32'sd2, 0);
        run_op("ovf_q", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("ovf_r", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("dz_u_q", 1'b0, 1'b0, 32'd5, 32'd0, 0);
        run_op("dz_u_r", 1'b0, 1'b1, 32'd5, 32'd0, 0);
        run_op("dz_s_r", 1'b1, 1'b1, -32'sd5, 32'd0, 0);
        run_op("zero_dvd", 1'b0, 1'b0, 32'd0, 32'd9, 0);
        run_op("backpressure", 1'b0, 1'b0, 32'd1000, 32'd7, 5);

        // Flush in the 4th ITER cycle
        @(negedge clk);
        in_valid = 1'b1; op_signed = 1'b0; op_rem = 1'b0; src1 = 32'd1000; src2 = 32'd3;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_idle", {62'd0, in_ready, busy}, {62'd0, 1'b1, 1'b0});
        pend = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) pend = 1'b1;
        end
        chk("flush_no_valid", 64'(pend), 64'd0);
        run_op("after_flush", 1'b0, 1'b0, 32'd9, 32'd3, 0);

        // Flush in IDLE blocks acceptance
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; src1 = 32'd9; src2 = 32'd3;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_idle_block", {62'd0, busy, in_ready}, {62'd0, 1'b0, 1'b1});

        for (int i = 0; i < 40; i++) begin
            ra = $urandom >> $urandom_range(0, 31);
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            if ($urandom_range(0, 1) == 1) ra = -ra;
            if ($urandom_range(0, 1) == 1) rb = -rb;
            run_op($sformatf("rnd%0d", i), 1'($urandom), 1'($urandom), ra, rb,
                   $urandom_range(0, 2));
        end

        run64("w64_q", 1'b0, 1'b0, 64'h8000_0000_0000_0001, 64'd3);
        run64("w64_r", 1'b0, 1'b1, 64'h8000_0000_0000_0001, 64'd3);
        run64("w64_s", 1'b1, 1'b0, -64'sd7, 64'd2);
        run64("w64_dz", 1'b0, 1'b1, 64'd12345, 64'd0);
        run64("w64_rnd", 1'b0, 1'b0, {$urandom, $urandom}, 64'($urandom));

        // Reset in the middle of ITER
        @(negedge clk);
        in_valid = 1'b1; op_signed = 1'b0; op_rem = 1'b0; src1 = 32'hFFFF_0000; src2 = 32'd7;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midreset_outs", {60'd0, in_ready, out_valid, busy, 1'b0}, 64'd0);
        chk("midreset_result", 64'(result), 64'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("midreset_ready", 64'(in_ready), 64'd1);
        run_op("after_reset", 1'b0, 1'b1, 32'd100, 32'd7, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
